// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encoding, port
// identifiers and default bus widths.
package mips_mem_pkg;

    localparam int LAT_W      = 4;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_lat_counter.sv
// Access latency counter: counts busy cycles and flags the last one
// (cnt == MEM_LAT-1) so the arbiter knows when to complete.
module arb_lat_counter
    import mips_mem_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LAT_W'(MEM_LAT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port unified memory with fixed access
// latency. Define MEM_ARB_FAIR_EN for round-robin instead of data priority.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no access in flight; arbitrate on i_req / d_req
// ST_IBUSY | fetch access in flight from latched address
// ST_DBUSY | data access (read or write) in flight from latched request
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall
);

    arb_state_e        state_q, state_d;
    logic              last_q,  last_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic busy;
    logic tc;
    logic pick_d;
    logic done;

    assign busy = (state_q != ST_IDLE);

    arb_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   ((state_q == ST_IDLE) | tc),
        .en    (busy),
        .tc    (tc)
    );

`ifdef MEM_ARB_FAIR_EN
    assign pick_d = d_req & (~i_req | (last_q == PORT_I));
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_d) begin
                    state_d = ST_DBUSY;
                    last_d  = PORT_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                end else if (i_req) begin
                    state_d = ST_IBUSY;
                    last_d  = PORT_I;
                    we_d    = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = '0;
                end
            end
            ST_IBUSY, ST_DBUSY: begin
                if (tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= PORT_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // A reset landing on the completion cycle must not leak a write or ready.
    assign done = busy & tc & ~reset;

    always_comb begin
        mem_en    = busy;
        mem_addr  = busy ? addr_q : '0;
        mem_we    = (state_q == ST_DBUSY) & we_q & done;
        mem_wdata = ((state_q == ST_DBUSY) & we_q) ? wdata_q : '0;
        i_ready   = (state_q == ST_IBUSY) & done;
        d_ready   = (state_q == ST_DBUSY) & done;
        i_rdata   = i_ready ? mem_rdata : '0;
        d_rdata   = (d_ready & ~we_q) ? mem_rdata : '0;
        stall     = (i_req & ~i_ready) | (d_req & ~d_ready);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MEM_LAT=2 and MEM_LAT=1).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [5:0]  i_addr, d_addr;
    logic [31:0] d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_wdata;
    logic        i_ready, d_ready, mem_en, mem_we, stall;
    logic [5:0]  mem_addr;

    logic        reset1, i_req1;
    logic [5:0]  i_addr1;
    logic [31:0] mem_rdata1;
    logic [31:0] i_rdata1, d_rdata1, mem_wdata1;
    logic        i_ready1, d_ready1, mem_en1, mem_we1, stall1;
    logic [5:0]  mem_addr1;

    int n_cmp = 0;
    int n_bad = 0;
    logic        first_d;
    logic [5:0]  win_addr, lose_addr;
    int          pulses;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(2)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_arbiter #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset1),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ready(i_ready1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(6'd0), .d_wdata(32'd0),
        .d_rdata(d_rdata1), .d_ready(d_ready1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .stall(stall1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;  reset1 = 1'b1;
        i_req = 1'b0;  d_req = 1'b0;  d_we = 1'b0;
        i_addr = '0;   d_addr = '0;   d_wdata = '0;
        i_req1 = 1'b0; i_addr1 = '0;
        mem_rdata  = 32'hDEADBEEF;
        mem_rdata1 = 32'hCAFE0001;
        repeat (2) step();

        check_val("rst_mem_en", mem_en, 0);
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_i_ready", i_ready, 0);
        check_val("rst_d_ready", d_ready, 0);
        check_val("rst_stall", stall, 0);

        // fetch read, requester drops req after grant
        reset = 1'b0; i_req = 1'b1; i_addr = 6'd5;
        #1;
        check_val("i_idle_stall", stall, 1);
        check_val("i_idle_en", mem_en, 0);
        step();
        check_val("i_c1_en", mem_en, 1);
        check_val("i_c1_addr", mem_addr, 5);
        check_val("i_c1_ready", i_ready, 0);
        check_val("i_c1_rdata", i_rdata, 0);
        i_req = 1'b0; i_addr = 6'd9;
        #1;
        check_val("i_c1_stall_drop", stall, 0);
        step();
        check_val("i_c2_en", mem_en, 1);
        check_val("i_c2_addr", mem_addr, 5);
        check_val("i_c2_ready", i_ready, 1);
        check_val("i_c2_rdata", i_rdata, 32'hDEADBEEF);
        check_val("i_c2_we", mem_we, 0);
        step();
        check_val("i_done_en", mem_en, 0);
        check_val("i_done_ready", i_ready, 0);
        check_val("i_done_rdata", i_rdata, 0);

        // data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd3; d_wdata = 32'h12;
        step();
        check_val("w_c1_en", mem_en, 1);
        check_val("w_c1_we", mem_we, 0);
        check_val("w_c1_addr", mem_addr, 3);
        check_val("w_c1_dready", d_ready, 0);
        d_req = 1'b0; d_addr = 6'd1; d_wdata = 32'h99;
        step();
        check_val("w_c2_we", mem_we, 1);
        check_val("w_c2_wdata", mem_wdata, 32'h12);
        check_val("w_c2_addr", mem_addr, 3);
        check_val("w_c2_dready", d_ready, 1);
        check_val("w_c2_drdata", d_rdata, 0);
        check_val("w_c2_iready", i_ready, 0);
        step();
        check_val("w_idle_we", mem_we, 0);
        check_val("w_idle_en", mem_en, 0);
        check_val("w_idle_dready", d_ready, 0);

        // contention; last grant was D
`ifdef MEM_ARB_FAIR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        win_addr  = first_d ? 6'd7 : 6'd2;
        lose_addr = first_d ? 6'd2 : 6'd7;
        mem_rdata = 32'hA5A50001;
        i_req = 1'b1; i_addr = 6'd2; d_req = 1'b1; d_we = 1'b0; d_addr = 6'd7;
        #1;
        check_val("arb_idle_stall", stall, 1);
        step();
        check_val("arb_w1_addr", mem_addr, 32'(win_addr));
        check_val("arb_w1_stall", stall, 1);
        step();
        check_val("arb_w2_iready", i_ready, first_d ? 0 : 1);
        check_val("arb_w2_dready", d_ready, first_d ? 1 : 0);
        check_val("arb_w2_irdata", i_rdata, first_d ? 32'h0 : 32'hA5A50001);
        check_val("arb_w2_drdata", d_rdata, first_d ? 32'hA5A50001 : 32'h0);
        check_val("arb_w2_stall", stall, 1);
        if (first_d) d_req = 1'b0;
        else         i_req = 1'b0;
        step();
        check_val("arb_gap_en", mem_en, 0);
        check_val("arb_gap_stall", stall, 1);
        step();
        check_val("arb_l1_en", mem_en, 1);
        check_val("arb_l1_addr", mem_addr, 32'(lose_addr));
        step();
        check_val("arb_l2_iready", i_ready, first_d ? 1 : 0);
        check_val("arb_l2_dready", d_ready, first_d ? 0 : 1);
        check_val("arb_l2_stall", stall, 0);
        i_req = 1'b0; d_req = 1'b0;
        step();
        check_val("arb_end_en", mem_en, 0);
        check_val("arb_end_stall", stall, 0);

        // reset in the first cycle of a write
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd3; d_wdata = 32'h55;
        step();
        check_val("rw_c1_en", mem_en, 1);
        check_val("rw_c1_we", mem_we, 0);
        reset = 1'b1;
        #1;
        check_val("rw_c1r_we", mem_we, 0);
        check_val("rw_c1r_dready", d_ready, 0);
        step();
        check_val("rw_a_en", mem_en, 0);
        check_val("rw_a_we", mem_we, 0);
        check_val("rw_a_dready", d_ready, 0);
        check_val("rw_a_stall", stall, 1);
        step();
        check_val("rw_b_en", mem_en, 0);
        check_val("rw_b_we", mem_we, 0);
        reset = 1'b0; d_req = 1'b0;
        step();
        check_val("rw_c_en", mem_en, 0);
        check_val("rw_c_we", mem_we, 0);
        check_val("rw_c_dready", d_ready, 0);

        // MEM_LAT=1, back-to-back fetches
        i_req1 = 1'b1; i_addr1 = 6'd4;
        step();
        check_val("l1_rst_en", mem_en1, 0);
        reset1 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (i_ready1) pulses++;
            check_val($sformatf("l1_ready_%0d", k), i_ready1, (k % 2 == 0) ? 1 : 0);
            check_val($sformatf("l1_en_%0d", k), mem_en1, (k % 2 == 0) ? 1 : 0);
            check_val($sformatf("l1_rdata_%0d", k), i_rdata1, (k % 2 == 0) ? 32'hCAFE0001 : 32'h0);
            check_val($sformatf("l1_addr_%0d", k), mem_addr1, (k % 2 == 0) ? 32'd4 : 32'd0);
            check_val($sformatf("l1_stall_%0d", k), stall1, (k % 2 == 0) ? 0 : 1);
            check_val($sformatf("l1_quiet_%0d", k),
                      {mem_we1, d_ready1, (d_rdata1 != 0), (mem_wdata1 != 0)}, 0);
        end
        check_val("l1_pulses", pulses, 3);
        i_req1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
